adsr_envelope: RTL and testbench

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/adsr_envelope.sv | 125 ++++++++++++
 tb/tb_adsr_envelope.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ============================================================================
// adsr_envelope : per-sample ADSR level generator driven by a note gate
// Revision 1.0
// ============================================================================
`default_nettype none

module adsr_envelope #(
  parameter int BITSIZE  = 16,
  parameter int RATEBITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                sample_en,
  input  logic                gate,
  input  logic [RATEBITS-1:0] att,
  input  logic [RATEBITS-1:0] dec,
  input  logic [RATEBITS-1:0] sus,
  input  logic [RATEBITS-1:0] rel,
  output logic [BITSIZE-1:0]  amplitude,
  output logic [2:0]          state,
  output logic                done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [RATEBITS-1:0] c_level_max = {RATEBITS{1'b1}};

  state_e              state_q, state_d;
  logic [RATEBITS-1:0] level_q, level_d;
  logic                gate_dly_q, gate_dly_d;
  logic                done_q, done_d;

  logic                gate_rise;
  logic                gate_fall;
  logic [RATEBITS:0]   attack_sum;
  logic [RATEBITS-1:0] decay_gap;

  assign gate_rise  = gate & ~gate_dly_q;
  assign gate_fall  = ~gate & gate_dly_q;
  assign attack_sum = {1'b0, level_q} + {1'b0, att};
  // Only meaningful when level_q > sus; guarded by the comparison ahead of it.
  assign decay_gap  = level_q - sus;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    done_d     = 1'b0;
    gate_dly_d = gate;

    // Gate edges win over a coincident sample strobe and leave the level alone,
    // so a retrigger continues from the current level without a click.
    if (gate_rise) begin
      state_d = ST_ATTACK;
    end else if (gate_fall) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_RELEASE;
      end
    end else if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          level_d = '0;
        end
        ST_ATTACK: begin
          if ((att == '0) || (attack_sum >= {1'b0, c_level_max})) begin
            level_d = c_level_max;
            state_d = ST_DECAY;
          end else begin
            level_d = attack_sum[RATEBITS-1:0];
          end
        end
        ST_DECAY: begin
          if ((level_q <= sus) || (decay_gap <= dec) || (dec == '0)) begin
            level_d = sus;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = level_q - dec;
          end
        end
        ST_SUSTAIN: begin
          level_d = sus;
        end
        ST_RELEASE: begin
          if ((level_q <= rel) || (rel == '0)) begin
            level_d = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - rel;
          end
        end
        default: begin
          level_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      gate_dly_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      gate_dly_q <= gate_dly_d;
      done_q     <= done_d;
    end
  end

  assign amplitude = {1'b0, level_q[RATEBITS-1 -: BITSIZE-1]};
  assign state     = state_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope.sv
// ============================================================================
// tb_adsr_envelope : directed self-checking bench for adsr_envelope
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_adsr_envelope;

  logic        clk;
  logic        resetn;
  logic        sample_en;
  logic        gate;
  logic [15:0] att;
  logic [15:0] dec;
  logic [15:0] sus;
  logic [15:0] rel;
  logic [15:0] amplitude;
  logic [2:0]  state;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  adsr_envelope #(.BITSIZE(16), .RATEBITS(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sample_en (sample_en),
    .gate      (gate),
    .att       (att),
    .dec       (dec),
    .sus       (sus),
    .rel       (rel),
    .amplitude (amplitude),
    .state     (state),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given sample strobe; outputs sampled 1 time unit after the edge.
  task automatic step(input logic se);
    sample_en = se;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    if (done === 1'b1) done_count++;
  endtask

  task automatic expect3(input string tag, input logic [15:0] amp, input logic [2:0] st,
                         input logic dn);
    check({tag, "_amp"}, {16'd0, amplitude}, {16'd0, amp});
    check({tag, "_state"}, {29'd0, state}, {29'd0, st});
    check({tag, "_done"}, {31'd0, done}, {31'd0, dn});
  endtask

  initial begin
    resetn = 1'b0; sample_en = 1'b0; gate = 1'b0;
    att = 16'h4000; dec = 16'h1000; sus = 16'h8000; rel = 16'h2000;
    step(1'b1);
    step(1'b1);
    expect3("reset", 16'h0000, 3'd0, 1'b0);

    resetn = 1'b1;
    step(1'b1);
    expect3("idle_tick", 16'h0000, 3'd0, 1'b0);

    // Attack ramp to full scale
    gate = 1'b1;
    step(1'b0);
    expect3("rise", 16'h0000, 3'd1, 1'b0);
    step(1'b0);
    expect3("attack_hold", 16'h0000, 3'd1, 1'b0);
    step(1'b1); expect3("atk1", 16'h2000, 3'd1, 1'b0);
    step(1'b1); expect3("atk2", 16'h4000, 3'd1, 1'b0);
    step(1'b1); expect3("atk3", 16'h6000, 3'd1, 1'b0);
    step(1'b1); expect3("atk4", 16'h7FFF, 3'd2, 1'b0);

    // Decay to sustain
    for (int i = 0; i < 7; i++) step(1'b1);
    expect3("dec7", 16'h47FF, 3'd2, 1'b0);
    step(1'b1);
    expect3("dec8", 16'h4000, 3'd3, 1'b0);
    step(1'b0);
    expect3("sus_hold", 16'h4000, 3'd3, 1'b0);
    sus = 16'h6000;
    step(1'b1);
    expect3("sus_track", 16'h3000, 3'd3, 1'b0);
    sus = 16'h8000;
    step(1'b1);
    expect3("sus_back", 16'h4000, 3'd3, 1'b0);

    // Falling edge coincident with sample strobe: level must not step
    gate = 1'b0;
    step(1'b1);
    expect3("fall_edge_se", 16'h4000, 3'd4, 1'b0);
    step(1'b1); expect3("rel1", 16'h3000, 3'd4, 1'b0);
    step(1'b1); expect3("rel2", 16'h2000, 3'd4, 1'b0);

    // Retrigger from release at L=0x4000
    gate = 1'b1;
    att = 16'h1000;
    step(1'b1);
    expect3("retrig", 16'h2000, 3'd1, 1'b0);
    step(1'b1);
    expect3("retrig_atk", 16'h2800, 3'd1, 1'b0);

    // Zero-rate attack and decay each take one tick
    att = 16'h0000; dec = 16'h0000;
    step(1'b1); expect3("att0", 16'h7FFF, 3'd2, 1'b0);
    step(1'b1); expect3("dec0", 16'h4000, 3'd3, 1'b0);

    // Full release from 0x8000: four ticks, one done pulse
    gate = 1'b0;
    step(1'b0);
    expect3("fall", 16'h4000, 3'd4, 1'b0);
    done_count = 0;
    step(1'b1); expect3("r1", 16'h3000, 3'd4, 1'b0);
    step(1'b1); expect3("r2", 16'h2000, 3'd4, 1'b0);
    step(1'b1); expect3("r3", 16'h1000, 3'd4, 1'b0);
    step(1'b1); expect3("r4", 16'h0000, 3'd0, 1'b1);
    step(1'b0); expect3("post_done", 16'h0000, 3'd0, 1'b0);
    step(1'b1); step(1'b1);
    expect3("idle_stay", 16'h0000, 3'd0, 1'b0);
    check("done_pulses", done_count, 32'd1);

    // rel=0 releases in one tick
    gate = 1'b1;
    step(1'b0); expect3("rise2", 16'h0000, 3'd1, 1'b0);
    step(1'b1); expect3("att0b", 16'h7FFF, 3'd2, 1'b0);
    step(1'b1); expect3("dec0b", 16'h4000, 3'd3, 1'b0);
    gate = 1'b0; rel = 16'h0000;
    step(1'b0); expect3("fall2", 16'h4000, 3'd4, 1'b0);
    step(1'b1); expect3("rel0", 16'h0000, 3'd0, 1'b1);

    // Reset mid-attack aborts without done; gate high at release retriggers
    gate = 1'b1; att = 16'h1000;
    step(1'b0);
    step(1'b1); step(1'b1);
    expect3("atk_mid", 16'h1000, 3'd1, 1'b0);
    done_count = 0;
    resetn = 1'b0;
    step(1'b1);
    expect3("reset_mid", 16'h0000, 3'd0, 1'b0);
    step(1'b1);
    expect3("reset_hold", 16'h0000, 3'd0, 1'b0);
    resetn = 1'b1;
    step(1'b1);
    expect3("post_reset_rise", 16'h0000, 3'd1, 1'b0);
    step(1'b1);
    expect3("post_reset_atk", 16'h0800, 3'd1, 1'b0);
    check("reset_no_done", done_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
